// File: rtl/rr_lane_xbar_pkg.sv
// Shared constants for the round-robin lane crossbar.
//   MODE_BCAST / MODE_ROT : encodings of the MODE input
//   DEFAULT_INV_MASK      : default per-lane inversion mask (lanes 0, 2, 4)
package rr_lane_xbar_pkg;
  localparam logic        MODE_BCAST       = 1'b0;
  localparam logic        MODE_ROT         = 1'b1;
  localparam logic [31:0] DEFAULT_INV_MASK = 32'h0000_0015;
endpackage

// File: rtl/rr_lane_xbar_lane.sv
// Combinational per-lane channel select and optional inversion.
//   IN       : all channels, channel c at [c*WD +: WD]
//   SEL      : current select counter value (always < NCH)
//   MODE     : MODE_BCAST takes channel SEL, MODE_ROT takes (SEL+LANE) mod NCH
//   INV      : invert this lane's data when set
//   LANE_OUT : selected (and possibly inverted) lane data
module rr_lane_xbar_lane
  import rr_lane_xbar_pkg::*;
#(
  parameter int WD   = 4,
  parameter int NCH  = 5,
  parameter int LANE = 0,
  parameter int CW   = $clog2(NCH)
) (
  input  logic [NCH*WD-1:0] IN,
  input  logic [CW-1:0]     SEL,
  input  logic              MODE,
  input  logic              INV,
  output logic [WD-1:0]     LANE_OUT
);

  localparam logic [CW:0] LANE_W = (CW+1)'(LANE);
  localparam logic [CW:0] NCH_W  = (CW+1)'(NCH);

  logic [WD-1:0] ch [NCH];
  logic [CW:0]   sum;
  logic [CW-1:0] rot_idx;
  logic [CW-1:0] src;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign ch[c] = IN[c*WD +: WD];
  end

  // SEL and LANE are both < NCH, so one conditional subtract reduces the
  // sum modulo NCH; the extra bit keeps it exact for non-power-of-two NCH.
  always_comb begin
    sum     = {1'b0, SEL} + LANE_W;
    rot_idx = (sum >= NCH_W) ? CW'(sum - NCH_W) : CW'(sum);
    src     = (MODE == MODE_ROT) ? rot_idx : SEL;
    LANE_OUT = INV ? ~ch[src] : ch[src];
  end

endmodule

// File: rtl/rr_lane_xbar.sv
// N-channel round-robin lane crossbar with a registered output stage.
//   CLK, RST_X          : clock, synchronous active-low reset
//   MODE                : 0=broadcast, 1=rotate; sampled on accept
//   CNT_CLR             : synchronous select-counter clear
//   IN_VALID / IN_READY : input handshake
//   IN                  : channel c at [c*WD +: WD]
//   OUT_VALID/OUT_READY : output handshake
//   OUT                 : lane i at [i*WD +: WD]
//   OUT_SEL             : select value that produced the current OUT
module rr_lane_xbar
  import rr_lane_xbar_pkg::*;
#(
  parameter int          WD       = 4,
  parameter int          NCH      = 5,
  parameter logic [31:0] INV_MASK = DEFAULT_INV_MASK,
  localparam int         CW       = $clog2(NCH)
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              MODE,
  input  logic              CNT_CLR,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [NCH*WD-1:0] IN,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [NCH*WD-1:0] OUT,
  output logic [CW-1:0]     OUT_SEL
);

  localparam logic [CW-1:0] SEL_MAX = CW'(NCH - 1);

  logic [CW-1:0]     sel;
  logic [NCH*WD-1:0] lane_data;
  logic              accept;

  assign IN_READY = !OUT_VALID || OUT_READY;
  assign accept   = IN_VALID && IN_READY;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    rr_lane_xbar_lane #(
      .WD   (WD),
      .NCH  (NCH),
      .LANE (i),
      .CW   (CW)
    ) u_lane (
      .IN       (IN),
      .SEL      (sel),
      .MODE     (MODE),
      .INV      (INV_MASK[i]),
      .LANE_OUT (lane_data[i*WD +: WD])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      sel       <= '0;
      OUT_VALID <= 1'b0;
      OUT       <= '0;
      OUT_SEL   <= '0;
    end else begin
      if (accept) begin
        OUT       <= lane_data;
        OUT_SEL   <= sel;
        OUT_VALID <= 1'b1;
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
      // Clear wins over increment; a same-cycle word already used the old sel.
      if (CNT_CLR)
        sel <= '0;
      else if (accept)
        sel <= (sel == SEL_MAX) ? '0 : sel + CW'(1);
    end
  end

endmodule

// File: doc/rr_lane_xbar.md
Name: rr_lane_xbar

Overview:
- N-channel round-robin lane crossbar with a registered output stage and a valid/ready handshake.
- A wrap-around select counter picks which input channel feeds each output lane:
  - broadcast mode: every lane takes the same channel;
  - rotate mode: lane i takes channel (sel+i) mod NCH.
- A per-lane inversion mask is applied to each lane's data.
- Parametrised successor of the fixed 5-channel counter-select/invert datapath; sits between channel sources and per-lane consumers.

Parameters:
- WD, 4, data width per channel (>=1)
- NCH, 5, channel/lane count (2..32)
- INV_MASK, 32'h00000015, bit i=1 inverts output lane i; bits >= NCH ignored
- CW, $clog2(NCH), select counter width (localparam, not overridable)

Ports:
- CLK  in  1  clock, all logic on posedge
- RST_X  in  1  reset, synchronous, active-low
- MODE  in  1  0=broadcast, 1=rotate; sampled on accept
- CNT_CLR  in  1  synchronous select-counter clear
- IN_VALID  in  1  input word valid
- IN_READY  out  1  block can accept
- IN  in  NCH*WD  channel c at bits [c*WD +: WD]
- OUT_VALID  out  1  output word valid
- OUT_READY  in  1  downstream accepts
- OUT  out  NCH*WD  lane i at bits [i*WD +: WD]
- OUT_SEL  out  CW  select value used to produce current OUT

Behaviour:
- Reset (RST_X=0 at posedge): sel=0, OUT_VALID=0, OUT=0, OUT_SEL=0. IN_READY=1 after reset (combinational). Reset overrides every other input.
- IN_READY = !OUT_VALID || OUT_READY (combinational; no comb path from IN_VALID).
- accept = IN_VALID && IN_READY. Latency 1 cycle: accepted word appears on OUT the next cycle.
- On accept:
  - lane i source channel = sel (MODE=0) or (sel+i) mod NCH (MODE=1).
  - OUT lane i <= source data, XORed with all-ones if INV_MASK[i].
  - OUT_SEL <= sel; OUT_VALID <= 1.
  - sel <= (sel==NCH-1) ? 0 : sel+1.
- No accept and OUT_READY=1: OUT_VALID <= 0; OUT and OUT_SEL hold.
- Stall (OUT_VALID && !OUT_READY): OUT, OUT_SEL, OUT_VALID and sel all hold; IN_READY=0.
- Rotate index: computed as sel+i reduced modulo NCH without relying on power-of-two wrap; correct for non-power-of-two NCH.
- sel never takes values >= NCH.
- CNT_CLR:
  - sel <= 0 at the edge, priority over increment.
  - If accept occurs in the same cycle, the word is mapped with the old sel, then sel=0.
  - Does not affect OUT, OUT_VALID or OUT_SEL.
- MODE change while stalled has no effect on the held output.

Decomposition:
- Shared package rr_lane_xbar_pkg: MODE_BCAST=1'b0, MODE_ROT=1'b1, default INV_MASK constant.
- One sub-module rr_lane_xbar_lane (combinational, generate-instantiated per lane).
  - Inputs: IN bus, sel, MODE, lane index parameter, invert bit.
  - Output: WD-bit lane data.
- Top holds the counter, handshake and output register.

Test Plan (WD=4, NCH=5, default INV_MASK; IN channels c0..c4 = 1,2,3,4,5):
- Reset, then IN_VALID=1, OUT_READY=1, MODE=0 for 6 cycles -> OUT_SEL sequence 0,1,2,3,4,0; first OUT lanes = {~1,1,~1,1,~1} = E,1,E,1,E; next word lanes = D,2,D,2,D.
- MODE=1 from sel=2 -> lanes take c2,c3,c4,c0,c1 = ~3,4,~5,1,~2 = C,4,A,1,D; OUT_SEL=2.
- OUT_READY=0 for 3 cycles with IN_VALID=1 -> IN_READY=0, OUT/OUT_SEL stable, sel not advanced. Release -> next word uses the next sel, no skip or duplicate.
- CNT_CLR=1 with accept at sel=3 -> that output has OUT_SEL=3; next accepted word has OUT_SEL=0.
- IN_VALID=0, OUT_READY=1 -> OUT_VALID drops after one cycle; sel unchanged.
- RST_X=0 while OUT_VALID=1 and stalled -> next cycle OUT_VALID=0, OUT=0, OUT_SEL=0; first post-reset word uses sel=0.
